// File: rtl/cntb_ctrl_if.sv
// Request, datapath and result signals of the count-bits controller.
// The slave modport is the controller side.
interface cntb_ctrl_if #(
    parameter int unsigned ID_W = 4
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;

    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_rs0_i;
    logic [IDX_W-1:0]  req0_rs1_i;
    logic [ID_W-1:0]   req0_id_i;

    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_rs0_i;
    logic [IDX_W-1:0]  req1_rs1_i;
    logic [ID_W-1:0]   req1_id_i;

    logic              cu_start_o;
    logic [DATA_W-1:0] cu_rs0_o;
    logic [DATA_W-1:0] cu_rs1_o;
    logic              cu_done_i;
    logic [DATA_W-1:0] cu_rd_i;

    logic              res_valid_o;
    logic              res_ready_i;
    logic [DATA_W-1:0] res_data_o;
    logic [ID_W-1:0]   res_id_o;
    logic              res_src_o;
    logic              res_err_o;

    modport slave (
        input  req0_valid_i, req0_rs0_i, req0_rs1_i, req0_id_i,
        input  req1_valid_i, req1_rs0_i, req1_rs1_i, req1_id_i,
        input  cu_done_i, cu_rd_i, res_ready_i,
        output req0_ready_o, req1_ready_o,
        output cu_start_o, cu_rs0_o, cu_rs1_o,
        output res_valid_o, res_data_o, res_id_o, res_src_o, res_err_o
    );

    modport master (
        output req0_valid_i, req0_rs0_i, req0_rs1_i, req0_id_i,
        output req1_valid_i, req1_rs0_i, req1_rs1_i, req1_id_i,
        output cu_done_i, cu_rd_i, res_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  cu_start_o, cu_rs0_o, cu_rs1_o,
        input  res_valid_o, res_data_o, res_id_o, res_src_o, res_err_o
    );
endinterface

// File: rtl/cntb_ctrl.sv
// Two-requester round-robin controller for the count-bits datapath:
// issues one operation at a time, bounds the wait, clamps and returns the result.
module cntb_ctrl #(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    cntb_ctrl_if.slave   bus,
    output logic         busy_o
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [DATA_W-1:0] MAX_RUN = DATA_W'(32);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              src_q, src_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              cu_start_q, cu_start_d;
    logic [DATA_W-1:0] cu_rs0_q, cu_rs0_d;
    logic [DATA_W-1:0] cu_rs1_q, cu_rs1_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_src_q, res_src_d;
    logic              res_err_q, res_err_d;
    logic              busy_q, busy_d;

    logic grant0, grant1, idle;

    // Pointer breaks ties; a lone valid requester always wins.
    assign grant0 = bus.req0_valid_i && (!bus.req1_valid_i || !ptr_q);
    assign grant1 = bus.req1_valid_i && (!bus.req0_valid_i || ptr_q);
    assign idle   = (state_q == S_IDLE) && !rst_i;

    assign bus.req0_ready_o = idle && grant0;
    assign bus.req1_ready_o = idle && grant1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        id_d        = id_q;
        cu_rs0_d    = cu_rs0_q;
        cu_rs1_d    = cu_rs1_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_src_d   = res_src_q;
        res_err_d   = res_err_q;
        cu_start_d  = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    state_d  = S_ISSUE;
                    src_d    = grant1;
                    ptr_d    = !grant1;
                    id_d     = grant1 ? bus.req1_id_i : bus.req0_id_i;
                    cu_rs0_d = grant1 ? bus.req1_rs0_i : bus.req0_rs0_i;
                    cu_rs1_d = grant1 ? DATA_W'(bus.req1_rs1_i) : DATA_W'(bus.req0_rs1_i);
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done wins over a coincident timeout.
                if (bus.cu_done_i || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d   = S_RESP;
                    cu_rs0_d  = '0;
                    cu_rs1_d  = '0;
                    res_id_d  = id_q;
                    res_src_d = src_q;
                    if (!bus.cu_done_i) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                    end else if (bus.cu_rd_i > MAX_RUN) begin
                        res_data_d = MAX_RUN;
                        res_err_d  = 1'b1;
                    end else begin
                        res_data_d = bus.cu_rd_i;
                        res_err_d  = 1'b0;
                    end
                end
            end
            default: begin
                if (bus.res_ready_i) begin
                    state_d    = S_IDLE;
                    res_data_d = '0;
                    res_id_d   = '0;
                    res_src_d  = 1'b0;
                    res_err_d  = 1'b0;
                end
            end
        endcase

        cu_start_d  = (state_d == S_ISSUE);
        res_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            src_q       <= 1'b0;
            id_q        <= '0;
            cu_start_q  <= 1'b0;
            cu_rs0_q    <= '0;
            cu_rs1_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_src_q   <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            id_q        <= id_d;
            cu_start_q  <= cu_start_d;
            cu_rs0_q    <= cu_rs0_d;
            cu_rs1_q    <= cu_rs1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_src_q   <= res_src_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cu_start_o  = cu_start_q;
    assign bus.cu_rs0_o    = cu_rs0_q;
    assign bus.cu_rs1_o    = cu_rs1_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;
    assign bus.res_id_o    = res_id_q;
    assign bus.res_src_o   = res_src_q;
    assign bus.res_err_o   = res_err_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_cntb_ctrl.sv
// Directed bench for cntb_ctrl: table of single transactions plus
// contention, backpressure and mid-operation reset sequences.
module tb_cntb_ctrl;
    localparam int unsigned ID_W = 4;
    localparam int TO = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_i = ~clk_i;

    cntb_ctrl_if #(.ID_W(ID_W)) bif ();

    cntb_ctrl #(.ID_W(ID_W), .TIMEOUT(TO)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bif),
        .busy_o (busy)
    );

    typedef struct {
        logic            src;
        logic [31:0]     rs0;
        logic [4:0]      rs1;
        logic [ID_W-1:0] id;
        int              dly;      // WAIT cycle carrying done (0: ISSUE only, >TO: never)
        logic [31:0]     rd;
        logic [31:0]     exp_data;
        logic            exp_err;
        int              exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        bif.req0_valid_i = 1'b0; bif.req0_rs0_i = '0; bif.req0_rs1_i = '0; bif.req0_id_i = '0;
        bif.req1_valid_i = 1'b0; bif.req1_rs0_i = '0; bif.req1_rs1_i = '0; bif.req1_id_i = '0;
        bif.cu_done_i    = 1'b0; bif.cu_rd_i    = '0; bif.res_ready_i = 1'b0;
    endtask

    task automatic set_req(input logic src, input logic v, input logic [31:0] rs0,
                           input logic [4:0] rs1, input logic [ID_W-1:0] id);
        if (src) begin
            bif.req1_valid_i = v; bif.req1_rs0_i = rs0; bif.req1_rs1_i = rs1; bif.req1_id_i = id;
        end else begin
            bif.req0_valid_i = v; bif.req0_rs0_i = rs0; bif.req0_rs1_i = rs1; bif.req0_id_i = id;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int  lat;
        logic got;
        set_req(v.src, 1'b1, v.rs0, v.rs1, v.id);
        #1;
        chk("grant_ready", 32'(v.src ? bif.req1_ready_o : bif.req0_ready_o), 32'd1);
        chk("other_ready", 32'(v.src ? bif.req0_ready_o : bif.req1_ready_o), 32'd0);
        tick();
        set_req(v.src, 1'b0, '0, '0, '0);
        bif.cu_done_i = (v.dly == 0);
        bif.cu_rd_i   = v.rd;
        #1;
        chk("issue_start", 32'(bif.cu_start_o), 32'd1);
        chk("issue_rs0", bif.cu_rs0_o, v.rs0);
        chk("issue_rs1", bif.cu_rs1_o, 32'(v.rs1));
        chk("issue_busy", 32'(busy), 32'd1);
        lat = 1;
        got = 1'b0;
        while (!got && lat < TO + 8) begin
            tick();
            lat++;
            bif.cu_done_i = (lat == v.dly + 1);
            if (bif.res_valid_o) got = 1'b1;
        end
        bif.cu_done_i = 1'b0;
        chk("result_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(lat), 32'(v.exp_lat));
            chk("res_data", bif.res_data_o, v.exp_data);
            chk("res_id", 32'(bif.res_id_o), 32'(v.id));
            chk("res_src", 32'(bif.res_src_o), 32'(v.src));
            chk("res_err", 32'(bif.res_err_o), 32'(v.exp_err));
            bif.res_ready_i = 1'b1;
            tick();
            bif.res_ready_i = 1'b0;
            chk("post_valid", 32'(bif.res_valid_o), 32'd0);
            chk("post_data", bif.res_data_o, 32'd0);
            chk("post_err", 32'(bif.res_err_o), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'hFF00_0000, 5'd31, 4'd3,  1,    32'd8,  32'd8,  1'b0, 3};
        vecs[1] = '{1'b1, 32'h0000_FFFF, 5'd0,  4'd9,  3,    32'd16, 32'd16, 1'b0, 5};
        vecs[2] = '{1'b0, 32'h1234_5678, 5'd4,  4'd5,  2,    32'd40, 32'd32, 1'b1, 4};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 5'd7,  4'd15, 1,    32'd32, 32'd32, 1'b0, 3};
        vecs[4] = '{1'b0, 32'h8000_0001, 5'd1,  4'd0,  1,    32'd33, 32'd32, 1'b1, 3};
        vecs[5] = '{1'b1, 32'h0F0F_0F0F, 5'd2,  4'd6,  1000, 32'd5,  32'd0,  1'b1, TO + 2};
        vecs[6] = '{1'b0, 32'hA5A5_A5A5, 5'd3,  4'd10, TO,   32'd12, 32'd12, 1'b0, TO + 2};
        vecs[7] = '{1'b1, 32'h0000_00FF, 5'd9,  4'd12, 0,    32'd7,  32'd0,  1'b1, TO + 2};

        // Reset values, with a requester already valid.
        drive_idle();
        rst_i = 1'b1;
        bif.req0_valid_i = 1'b1;
        tick();
        tick();
        chk("rst_ready0", 32'(bif.req0_ready_o), 32'd0);
        chk("rst_start", 32'(bif.cu_start_o), 32'd0);
        chk("rst_rs0", bif.cu_rs0_o, 32'd0);
        chk("rst_rs1", bif.cu_rs1_o, 32'd0);
        chk("rst_valid", 32'(bif.res_valid_o), 32'd0);
        chk("rst_data", bif.res_data_o, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        drive_idle();
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Contention: both valid continuously from reset, expect 0,1,0,1.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        set_req(1'b0, 1'b1, 32'h0000_AAAA, 5'd1, 4'd1);
        set_req(1'b1, 1'b1, 32'h0000_BBBB, 5'd2, 4'd2);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_grant", 32'({bif.req1_ready_o, bif.req0_ready_o}),
                (k % 2 == 1) ? 32'd2 : 32'd1);
            tick();
            chk("cont_start", 32'(bif.cu_start_o), 32'd1);
            chk("cont_rs0", bif.cu_rs0_o, (k % 2 == 1) ? 32'h0000_BBBB : 32'h0000_AAAA);
            tick();
            bif.cu_done_i = 1'b1;
            bif.cu_rd_i   = 32'(k + 1);
            tick();
            bif.cu_done_i = 1'b0;
            chk("cont_valid", 32'(bif.res_valid_o), 32'd1);
            chk("cont_src", 32'(bif.res_src_o), 32'(k % 2));
            chk("cont_id", 32'(bif.res_id_o), (k % 2 == 1) ? 32'd2 : 32'd1);
            chk("cont_data", bif.res_data_o, 32'(k + 1));
            bif.res_ready_i = 1'b1;
            #1;
            chk("cont_hs_ready", 32'(bif.req0_ready_o | bif.req1_ready_o), 32'd0);
            tick();
            bif.res_ready_i = 1'b0;
        end
        drive_idle();

        // Backpressure on a clamped result; done pulses in RESP are ignored.
        set_req(1'b1, 1'b1, 32'h0000_0F00, 5'd8, 4'd7);
        tick();
        set_req(1'b1, 1'b0, '0, '0, '0);
        tick();
        bif.cu_done_i = 1'b1;
        bif.cu_rd_i   = 32'd40;
        tick();
        bif.cu_rd_i = 32'd7;
        set_req(1'b0, 1'b1, 32'h0000_1111, 5'd0, 4'd4);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(bif.res_valid_o), 32'd1);
            chk("bp_data", bif.res_data_o, 32'd32);
            chk("bp_err", 32'(bif.res_err_o), 32'd1);
            chk("bp_id", 32'(bif.res_id_o), 32'd7);
            chk("bp_src", 32'(bif.res_src_o), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready0", 32'(bif.req0_ready_o), 32'd0);
            tick();
        end
        drive_idle();
        bif.res_ready_i = 1'b1;
        tick();
        bif.res_ready_i = 1'b0;
        chk("bp_done_busy", 32'(busy), 32'd0);
        chk("bp_done_valid", 32'(bif.res_valid_o), 32'd0);

        // Reset during WAIT discards the operation.
        set_req(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd5, 4'd4);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rs0", bif.cu_rs0_o, 32'd0);
        chk("midrst_rs1", bif.cu_rs1_o, 32'd0);
        chk("midrst_valid", 32'(bif.res_valid_o), 32'd0);
        tick();
        rst_i = 1'b0;
        bif.cu_done_i = 1'b1;
        bif.cu_rd_i   = 32'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ghost_valid", 32'(bif.res_valid_o), 32'd0);
            chk("ghost_busy", 32'(busy), 32'd0);
        end
        drive_idle();
        run_txn(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cntb_ctrl.md
CNTB_CTRL -- requirements
Module: cntb_ctrl

Interface
REQ-001 Parameter ID_W, default 4, sets the width of the instruction tag.
REQ-002 Parameter TIMEOUT, default 16, is the maximum number of cycles the block waits for the datapath to finish, range 2..255.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 reqN_valid_i (N=0,1)  in  1  requester N presents an operation.
REQ-006 reqN_ready_o  out  1  requester N's operation is accepted this cycle.
REQ-007 reqN_rs0_i  in  32  operand word to scan.
REQ-008 reqN_rs1_i  in  5  start bit index.
REQ-009 reqN_id_i  in  ID_W  instruction tag.
REQ-010 cu_start_o  out  1  start pulse to the count-bits datapath.
REQ-011 cu_rs0_o / cu_rs1_o  out  32 / 32  latched operands; cu_rs1_o is rs1 zero-extended.
REQ-012 cu_done_i  in  1  datapath finished; cu_rd_i is valid in the same cycle.
REQ-013 cu_rd_i  in  32  run-length result from the datapath.
REQ-014 res_valid_o / res_ready_i  out / in  1 / 1  result handshake.
REQ-015 res_data_o  out  32  result value.
REQ-016 res_id_o  out  ID_W  tag of the result.
REQ-017 res_src_o  out  1  index of the requester that owns the result.
REQ-018 res_err_o  out  1  result was produced by a timeout.
REQ-019 busy_o  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE behaviour:
- reqN_ready_o = 1 only for the granted requester, and only when its valid is high.
- An accepted request latches rs0, rs1, id and src, then the FSM moves to ISSUE.
REQ-022 Arbitration is round-robin using a 1-bit priority pointer, reset value 0.
- If both requesters are valid, the pointed-to requester wins.
- If only one is valid, that one wins.
- After each grant the pointer is set to the non-granted index.
REQ-023 ISSUE:
- cu_start_o = 1 for exactly one cycle.
- The wait counter is cleared.
- The FSM moves to WAIT unconditionally.
REQ-024 cu_rs0_o and cu_rs1_o SHALL hold the latched operands from ISSUE until leaving WAIT, and SHALL be 0 in IDLE.
REQ-025 WAIT: the counter increments every cycle. One of these applies:
- cu_done_i = 1: capture cu_rd_i, set err = 0, move to RESP.
- Counter reaches TIMEOUT without done: data = 0, err = 1, move to RESP.
REQ-026 If done and the timeout occur in the same cycle, done SHALL take priority (err = 0).
REQ-027 The captured result SHALL be clamped: any value greater than 32 is replaced by 32 and err is set to 1.
REQ-028 cu_done_i SHALL be ignored in the IDLE, ISSUE and RESP states.
REQ-029 RESP:
- res_valid_o = 1, and res_data_o, res_id_o, res_src_o, res_err_o stay stable until res_ready_i = 1.
- On the handshake the FSM returns to IDLE.
- No new request is accepted in the handshake cycle; minimum spacing between results is 4 cycles.
REQ-030 The res_* outputs SHALL be 0 whenever res_valid_o = 0.
REQ-031 The best-case latency from request acceptance to res_valid_o is 3 cycles, when done arrives in the first WAIT cycle.

Reset
REQ-032 When rst_i asserts, in any state, the block SHALL immediately enter IDLE.
REQ-033 Reset values of outputs and state:
- All outputs are 0: ready, cu_start_o, cu_rs0_o, cu_rs1_o, res_*, busy_o.
- Priority pointer and wait counter are 0.
REQ-034 An operation in flight when reset asserts SHALL be discarded with no result produced.
REQ-035 The first request may be accepted in the first cycle after rst_i deasserts.

Verification
REQ-036 Single request, no contention:
- Stimulus: req0 rs0=0xFF000000, rs1=31, id=3; cu_done_i 1 cycle after start with cu_rd_i=8.
- Response: res_data_o=8, res_id_o=3, res_src_o=0, res_err_o=0, res_valid_o 3 cycles after acceptance.
REQ-037 Contention:
- Stimulus: both requesters valid continuously after reset.
- Response: grant order is 0,1,0,1; each result carries the matching src and id.
REQ-038 Timeout:
- Stimulus: cu_done_i held 0.
- Response: res_valid_o rises TIMEOUT+2 cycles after acceptance, with data=0 and err=1.
- Variant: cu_done_i arriving in the timeout cycle gives err=0.
REQ-039 Backpressure and clamp:
- Stimulus: res_ready_i held 0 for 10 cycles.
- Response: res_* stay stable, no new request is accepted, and busy_o = 1.
- Clamp case: cu_rd_i=40 gives res_data_o=32 and res_err_o=1.
REQ-040 Reset mid-operation:
- Stimulus: assert rst_i during WAIT.
- Response: outputs go to 0 without waiting for a clock edge; a later cu_done_i produces no result.
- After release, a new request completes normally.
